// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
`timescale 1ns/1ps
package rf_arb_pkg;

    localparam int PROT_BASE = 13;
    localparam int PRIV_ID   = 31;
    localparam int ERR_CNT_W = 8;
    localparam int RF_ADDR_W = 4;
    localparam int RF_DATA_W = 16;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] wa;
        logic [RF_DATA_W-1:0] wd;
        logic [RF_DATA_W-1:0] uid;
    } wr_req_t;

    typedef enum logic [1:0] {WR_LEGAL, WR_DROP, WR_BLOCK} wr_class_t;

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin grant: first valid request at or above ptr, wrapping.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(ptr_i) + k) % NREQ;
            if (en_i && !found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin sharing of the register-file write port with privileged-register
// protection, one output register stage and a saturating violation counter.
`timescale 1ns/1ps
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int PROT_BASE = rf_arb_pkg::PROT_BASE,
    parameter int PRIV_ID   = rf_arb_pkg::PRIV_ID
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   STALL,
    input  logic [NREQ-1:0]        REQ_VALID,
    output logic [NREQ-1:0]        REQ_READY,
    input  logic [NREQ*ADDR_W-1:0] REQ_WA,
    input  logic [NREQ*DATA_W-1:0] REQ_WD,
    input  logic [NREQ*DATA_W-1:0] REQ_UID,
    output logic                   RF_EN,
    output logic [ADDR_W-1:0]      RF_WA,
    output logic [DATA_W-1:0]      RF_WD,
    output logic [DATA_W-1:0]      RF_UID,
    input  logic                   ERR_CLR,
    output logic                   ERR_FLAG,
    output logic [ERR_CNT_W-1:0]   ERR_CNT
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_W-1:0] PROT_LO  = ADDR_W'(PROT_BASE);
    localparam logic [DATA_W-1:0] PRIV_UID = DATA_W'(PRIV_ID);

    logic [IDX_W-1:0]     ptr_q, ptr_d, gnt_idx;
    logic                 rf_en_q, rf_en_d;
    logic [ADDR_W-1:0]    rf_wa_q, rf_wa_d, sel_wa;
    logic [DATA_W-1:0]    rf_wd_q, rf_wd_d, sel_wd;
    logic [DATA_W-1:0]    rf_uid_q, rf_uid_d, sel_uid;
    logic                 err_flag_q, err_flag_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d, cnt_base;
    logic                 xfer, viol;
    wr_class_t            cls;

    function automatic wr_class_t classify(input logic [ADDR_W-1:0] wa,
                                           input logic [DATA_W-1:0] uid);
        if (wa == '0)                             return WR_DROP;
        else if (wa >= PROT_LO && uid != PRIV_UID) return WR_BLOCK;
        else                                      return WR_LEGAL;
    endfunction

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .req_i (REQ_VALID),
        .ptr_i (ptr_q),
        .en_i  (!STALL),
        .gnt_o (REQ_READY),
        .idx_o (gnt_idx)
    );

    always_comb begin
        xfer    = |REQ_READY;
        sel_wa  = REQ_WA[int'(gnt_idx)*ADDR_W +: ADDR_W];
        sel_wd  = REQ_WD[int'(gnt_idx)*DATA_W +: DATA_W];
        sel_uid = REQ_UID[int'(gnt_idx)*DATA_W +: DATA_W];
        cls     = classify(sel_wa, sel_uid);
        viol    = xfer && (cls == WR_BLOCK);

        ptr_d = ptr_q;
        if (xfer)
            ptr_d = (gnt_idx == IDX_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

        rf_en_d  = xfer && (cls == WR_LEGAL);
        rf_wa_d  = rf_en_d ? sel_wa  : rf_wa_q;
        rf_wd_d  = rf_en_d ? sel_wd  : rf_wd_q;
        rf_uid_d = rf_en_d ? sel_uid : rf_uid_q;

        // Clear takes effect before the violation in the same cycle is counted.
        cnt_base   = ERR_CLR ? '0 : err_cnt_q;
        err_cnt_d  = (viol && cnt_base != '1) ? cnt_base + 1'b1 : cnt_base;
        err_flag_d = (ERR_CLR ? 1'b0 : err_flag_q) | viol;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q      <= '0;
            rf_en_q    <= 1'b0;
            rf_wa_q    <= '0;
            rf_wd_q    <= '0;
            rf_uid_q   <= '0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rf_en_q    <= rf_en_d;
            rf_wa_q    <= rf_wa_d;
            rf_wd_q    <= rf_wd_d;
            rf_uid_q   <= rf_uid_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign RF_EN    = rf_en_q;
    assign RF_WA    = rf_wa_q;
    assign RF_WD    = rf_wd_q;
    assign RF_UID   = rf_uid_q;
    assign ERR_FLAG = err_flag_q;
    assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a behavioural register-file model.
`timescale 1ns/1ps
module tb_rf_write_arbiter;

    localparam int NREQ   = 3;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic                   CLK = 1'b0;
    logic                   RST_N;
    logic                   STALL;
    logic [NREQ-1:0]        REQ_VALID;
    logic [NREQ-1:0]        REQ_READY;
    logic [NREQ*ADDR_W-1:0] REQ_WA;
    logic [NREQ*DATA_W-1:0] REQ_WD;
    logic [NREQ*DATA_W-1:0] REQ_UID;
    logic                   RF_EN;
    logic [ADDR_W-1:0]      RF_WA;
    logic [DATA_W-1:0]      RF_WD;
    logic [DATA_W-1:0]      RF_UID;
    logic                   ERR_CLR;
    logic                   ERR_FLAG;
    logic [7:0]             ERR_CNT;

    logic [DATA_W-1:0] rf_model [16];

    int n_assert = 0;
    int n_fail   = 0;

    rf_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .STALL     (STALL),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WA    (REQ_WA),
        .REQ_WD    (REQ_WD),
        .REQ_UID   (REQ_UID),
        .RF_EN     (RF_EN),
        .RF_WA     (RF_WA),
        .RF_WD     (RF_WD),
        .RF_UID    (RF_UID),
        .ERR_CLR   (ERR_CLR),
        .ERR_FLAG  (ERR_FLAG),
        .ERR_CNT   (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    // The register file commits whatever the arbiter presents at the edge.
    always @(posedge CLK) begin
        if (RF_EN) rf_model[RF_WA] <= RF_WD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] wa, input logic [15:0] wd,
                           input logic [15:0] uid);
        REQ_WA[i*ADDR_W +: ADDR_W]  = wa;
        REQ_WD[i*DATA_W +: DATA_W]  = wd;
        REQ_UID[i*DATA_W +: DATA_W] = uid;
    endtask

    initial begin
        logic [2:0]  exp_rdy [4];
        logic [3:0]  exp_wa  [4];
        exp_rdy[0] = 3'b010; exp_rdy[1] = 3'b100; exp_rdy[2] = 3'b001; exp_rdy[3] = 3'b010;
        exp_wa[0]  = 4'd1;   exp_wa[1]  = 4'd2;   exp_wa[2]  = 4'd3;   exp_wa[3]  = 4'd1;

        RST_N = 1'b0; STALL = 1'b0; ERR_CLR = 1'b0;
        REQ_VALID = '0; REQ_WA = '0; REQ_WD = '0; REQ_UID = '0;
        #2;
        chk("rst_rf_en",  RF_EN, 0);
        chk("rst_rf_wa",  RF_WA, 0);
        chk("rst_rf_wd",  RF_WD, 0);
        chk("rst_rf_uid", RF_UID, 0);
        chk("rst_flag",   ERR_FLAG, 0);
        chk("rst_cnt",    ERR_CNT, 0);
        chk("rst_ready_idle", REQ_READY, 3'b000);
        REQ_VALID = 3'b111; #1;
        chk("rst_ready_ptr0", REQ_READY, 3'b001);
        REQ_VALID = '0;
        tick(); tick();
        RST_N = 1'b1;

        // Fairness: all three valid continuously
        for (int i = 0; i < NREQ; i++) set_req(i, 4'(1 + i), 16'(16'h1000 + i), 16'(i));
        REQ_VALID = 3'b111; #1;
        chk("fair_ready_first", REQ_READY, 3'b001);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fair_rf_en", RF_EN, 1);
            chk("fair_rf_wa", RF_WA, exp_wa[k]);
            chk("fair_rf_wd", RF_WD, 32'h1000 + exp_wa[k] - 1);
            chk("fair_ready", REQ_READY, exp_rdy[k]);
        end
        REQ_VALID = '0;
        tick();
        chk("fair_idle_en", RF_EN, 0);
        chk("fair_idle_wa_hold", RF_WA, 1);

        // Privileged write to a protected register (ptr=1)
        set_req(1, 4'd14, 16'hBEEF, 16'd31);
        REQ_VALID = 3'b010; #1;
        chk("priv_ready", REQ_READY, 3'b010);
        tick();
        chk("priv_rf_en", RF_EN, 1);
        chk("priv_rf_wa", RF_WA, 14);
        chk("priv_rf_wd", RF_WD, 16'hBEEF);
        chk("priv_rf_uid", RF_UID, 31);
        chk("priv_cnt", ERR_CNT, 0);
        REQ_VALID = '0;
        tick();
        chk("priv_rf_commit", rf_model[14], 16'hBEEF);
        chk("priv_en_low", RF_EN, 0);

        // Unprivileged write to protected register (ptr=2)
        set_req(2, 4'd15, 16'h5555, 16'd7);
        REQ_VALID = 3'b100; #1;
        chk("unpriv_ready", REQ_READY, 3'b100);
        tick();
        chk("unpriv_rf_en", RF_EN, 0);
        chk("unpriv_flag", ERR_FLAG, 1);
        chk("unpriv_cnt", ERR_CNT, 1);
        chk("unpriv_wa_hold", RF_WA, 14);
        repeat (253) tick();
        chk("unpriv_cnt_254", ERR_CNT, 254);
        repeat (47) tick();
        chk("unpriv_cnt_sat", ERR_CNT, 255);
        chk("unpriv_rf_en_sat", RF_EN, 0);
        REQ_VALID = '0;
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        chk("clr_cnt", ERR_CNT, 0);
        chk("clr_flag", ERR_FLAG, 0);

        // Write to R0 is dropped silently (ptr=0)
        set_req(0, 4'd0, 16'hFFFF, 16'd31);
        REQ_VALID = 3'b001; #1;
        chk("r0_ready", REQ_READY, 3'b001);
        tick();
        chk("r0_rf_en", RF_EN, 0);
        chk("r0_cnt", ERR_CNT, 0);
        chk("r0_flag", ERR_FLAG, 0);
        chk("r0_wd_hold", RF_WD, 16'hBEEF);

        // First protected index with user 0 is a violation (ptr=1)
        set_req(1, 4'd13, 16'h1313, 16'd0);
        REQ_VALID = 3'b010; #1;
        chk("base_ready", REQ_READY, 3'b010);
        tick();
        chk("base_rf_en", RF_EN, 0);
        chk("base_cnt", ERR_CNT, 1);

        // Clear colliding with a violation (ptr=2)
        REQ_VALID = 3'b100;
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        chk("coll_cnt", ERR_CNT, 1);
        chk("coll_flag", ERR_FLAG, 1);

        // Highest unprotected index is legal for any user (ptr=0)
        set_req(0, 4'd12, 16'h0C0C, 16'd0);
        REQ_VALID = 3'b001;
        tick();
        chk("r12_rf_en", RF_EN, 1);
        chk("r12_rf_wa", RF_WA, 12);
        chk("r12_cnt", ERR_CNT, 1);

        // Stall with all requesters valid (ptr=1)
        for (int i = 0; i < NREQ; i++) set_req(i, 4'(1 + i), 16'(16'h1000 + i), 16'(i));
        REQ_VALID = 3'b111; #1;
        chk("pre_stall_ready", REQ_READY, 3'b010);
        tick();
        STALL = 1'b1; #1;
        chk("stall_ready_0", REQ_READY, 3'b000);
        chk("stall_pending_en", RF_EN, 1);
        chk("stall_pending_wa", RF_WA, 2);
        tick();
        chk("stall_ready_1", REQ_READY, 3'b000);
        chk("stall_en_1", RF_EN, 0);
        chk("stall_commit", rf_model[2], 16'h1001);
        tick();
        chk("stall_ready_2", REQ_READY, 3'b000);
        chk("stall_en_2", RF_EN, 0);
        tick();
        STALL = 1'b0;
        set_req(2, 4'd3, 16'h7777, 16'd2); #1;
        chk("unstall_ready", REQ_READY, 3'b100);
        tick();
        chk("unstall_rf_en", RF_EN, 1);
        chk("unstall_rf_wa", RF_WA, 3);
        chk("unstall_rf_wd", RF_WD, 16'h7777);

        // Reset in the cycle where RF_EN is high
        RST_N = 1'b0; #1;
        chk("rstmid_en_async", RF_EN, 0);
        chk("rstmid_ready_ptr0", REQ_READY, 3'b001);
        tick();
        chk("rstmid_rf_unchanged", rf_model[3], 16'h1002);
        chk("rstmid_wa", RF_WA, 0);
        chk("rstmid_wd", RF_WD, 0);
        chk("rstmid_cnt", ERR_CNT, 0);
        REQ_VALID = '0;
        RST_N = 1'b1;
        tick();
        chk("post_rst_en", RF_EN, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
